// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the datapath.
// ILLEGAL_TRAP_EN widens state_o to 4 bits and adds illegal_o.
interface multicycle_control_unit_if #(
   parameter int CNT_WIDTH = 32
);
   logic [6:0]           opcode_i;
   logic                 mem_ready_i;
   logic [2:0]           ALU_Op_o;
   logic                 ALU_Src_B_o;
   logic                 IR_Write_o;
   logic                 PC_Write_o;
   logic                 I_or_D_o;
   logic                 Mem_Read_o;
   logic                 Mem_Write_o;
   logic                 Reg_Write_o;
   logic                 Mem_to_Reg_o;
   logic [CNT_WIDTH-1:0] instr_count_o;
`ifdef ILLEGAL_TRAP_EN
   logic [3:0]           state_o;
   logic                 illegal_o;
`else
   logic [2:0]           state_o;
`endif

   modport master (
      input  opcode_i, mem_ready_i,
`ifdef ILLEGAL_TRAP_EN
      output illegal_o,
`endif
      output ALU_Op_o, ALU_Src_B_o, IR_Write_o, PC_Write_o,
      output I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
      output Mem_to_Reg_o, state_o, instr_count_o
   );

   modport slave (
      output opcode_i, mem_ready_i,
`ifdef ILLEGAL_TRAP_EN
      input  illegal_o,
`endif
      input  ALU_Op_o, ALU_Src_B_o, IR_Write_o, PC_Write_o,
      input  I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
      input  Mem_to_Reg_o, state_o, instr_count_o
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the shared RV32I-subset multicycle datapath.
// ILLEGAL_TRAP_EN: illegal opcodes park the FSM in HALT until reset.
module multicycle_control_unit #(
   parameter int       CNT_WIDTH = 32,
   parameter bit [2:0] ALUOP_R   = 3'b000,
   parameter bit [2:0] ALUOP_I   = 3'b001,
   parameter bit [2:0] ALUOP_LUI = 3'b010,
   parameter bit [2:0] ALUOP_SW  = 3'b011,
   parameter bit [2:0] ALUOP_LW  = 3'b100
) (
   input logic                        clk,
   input logic                        reset,
   multicycle_control_unit_if.master  bus
);
`ifdef ILLEGAL_TRAP_EN
   localparam int SW = 4;
`else
   localparam int SW = 3;
`endif

   typedef enum logic [SW-1:0] {
      FETCH  = SW'(0),
      DECODE = SW'(1),
      EXEC   = SW'(2),
      ALU_WB = SW'(3),
      ADDR   = SW'(4),
      MEM_RD = SW'(5),
      MEM_WB = SW'(6),
`ifdef ILLEGAL_TRAP_EN
      MEM_WR = SW'(7),
      HALT   = SW'(8)
`else
      MEM_WR = SW'(7)
`endif
   } state_t;

   typedef enum logic [2:0] {
      CL_R, CL_I, CL_LUI, CL_LW, CL_SW, CL_ILL
   } cls_t;

   state_t               state;
   cls_t                 cls;
   cls_t                 dec_cls;
   logic [CNT_WIDTH-1:0] cnt;
   logic [2:0]           exec_op;

   function automatic cls_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: classify = CL_R;
         7'b0010011: classify = CL_I;
         7'b0110111: classify = CL_LUI;
         7'b0000011: classify = CL_LW;
         7'b0100011: classify = CL_SW;
         default:    classify = CL_ILL;
      endcase
   endfunction

   assign dec_cls = classify(bus.opcode_i);

   // State, latched instruction class and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         cls   <= CL_R;
         cnt   <= '0;
      end else begin
         case (state)
            FETCH:  if (bus.mem_ready_i) state <= DECODE;
            DECODE: begin
               cls <= dec_cls;
               case (dec_cls)
                  CL_R, CL_I, CL_LUI: state <= EXEC;
                  CL_LW, CL_SW:       state <= ADDR;
`ifdef ILLEGAL_TRAP_EN
                  default:            state <= HALT;
`else
                  default:            state <= FETCH;
`endif
               endcase
            end
            EXEC:   state <= ALU_WB;
            ALU_WB: begin
               state <= FETCH;
               cnt   <= cnt + 1'b1;
            end
            ADDR:   state <= (cls == CL_LW) ? MEM_RD : MEM_WR;
            MEM_RD: if (bus.mem_ready_i) state <= MEM_WB;
            MEM_WB: begin
               state <= FETCH;
               cnt   <= cnt + 1'b1;
            end
            MEM_WR: if (bus.mem_ready_i) begin
               state <= FETCH;
               cnt   <= cnt + 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            HALT:   state <= HALT;
`endif
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      case (cls)
         CL_I:    exec_op = ALUOP_I;
         CL_LUI:  exec_op = ALUOP_LUI;
         default: exec_op = ALUOP_R;
      endcase
   end

   // Output decode of state and class; only IR/PC writes see mem_ready_i
   always_comb begin
      bus.ALU_Op_o     = ALUOP_R;
      bus.ALU_Src_B_o  = 1'b0;
      bus.IR_Write_o   = 1'b0;
      bus.PC_Write_o   = 1'b0;
      bus.I_or_D_o     = 1'b0;
      bus.Mem_Read_o   = 1'b0;
      bus.Mem_Write_o  = 1'b0;
      bus.Reg_Write_o  = 1'b0;
      bus.Mem_to_Reg_o = 1'b0;
      case (state)
         FETCH: begin
            bus.Mem_Read_o = 1'b1;
            bus.IR_Write_o = bus.mem_ready_i & reset;
            bus.PC_Write_o = bus.mem_ready_i & reset;
         end
         EXEC, ALU_WB: begin
            bus.ALU_Op_o    = exec_op;
            bus.ALU_Src_B_o = (cls != CL_R);
            bus.Reg_Write_o = (state == ALU_WB);
         end
         ADDR, MEM_RD, MEM_WR: begin
            bus.ALU_Op_o    = (cls == CL_LW) ? ALUOP_LW : ALUOP_SW;
            bus.ALU_Src_B_o = 1'b1;
            bus.I_or_D_o    = (state != ADDR);
            bus.Mem_Read_o  = (state == MEM_RD);
            bus.Mem_Write_o = (state == MEM_WR);
         end
         MEM_WB: begin
            bus.Reg_Write_o  = 1'b1;
            bus.Mem_to_Reg_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state_o       = state;
   assign bus.instr_count_o = cnt;
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal_o     = (state == HALT);
`endif
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the shared RV32I-subset datapath over multiple cycles: fetch, decode, execute, memory access and writeback.
- Drives the 3-bit ALU_Op field consumed by the ALU control decoder. Also drives register-file, memory, IR and PC enables.
- Handshakes with a variable-latency unified instruction/data memory through mem_ready_i.
- Sits between the instruction register and the datapath muxes and enables.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter
- ALUOP_R, 3'b000, ALU_Op code for R-type
- ALUOP_I, 3'b001, ALU_Op code for I-type ALU
- ALUOP_LUI, 3'b010, ALU_Op code for LUI
- ALUOP_SW, 3'b011, ALU_Op code for store address
- ALUOP_LW, 3'b100, ALU_Op code for load address

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode_i  input  7  IR[6:0], valid from DECODE onward
- mem_ready_i  input  1  memory completes current read/write this cycle
- ALU_Op_o  output  3  ALU class code to ALU control decoder
- ALU_Src_B_o  output  1  0=rs2, 1=immediate
- IR_Write_o  output  1  load instruction register
- PC_Write_o  output  1  PC <= PC+4
- I_or_D_o  output  1  memory address select: 0=PC, 1=ALU result
- Mem_Read_o  output  1  memory read request
- Mem_Write_o  output  1  memory write request
- Reg_Write_o  output  1  register-file write enable
- Mem_to_Reg_o  output  1  writeback select: 0=ALU, 1=memory data
- state_o  output  3  current state, for debug
- instr_count_o  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (asynchronous, active-low): state <= FETCH, class register <= R, instr_count_o <= 0.
- While reset is asserted, outputs decode FETCH: Mem_Read_o=1, I_or_D_o=0, all other enables 0, ALU_Op_o=000, ALU_Src_B_o=0.
- Outputs are a pure decode of state plus the latched class. IR_Write_o and PC_Write_o are the only outputs that also depend on mem_ready_i.
- Class latched on the DECODE cycle from opcode_i:
  - 0110011 = R
  - 0010011 = I
  - 0110111 = LUI
  - 0000011 = LW
  - 0100011 = SW
  - anything else = ILLEGAL
- State encoding and transitions:
  - FETCH (0): Mem_Read=1, I_or_D=0. Stay while mem_ready_i=0. When ready: IR_Write=1 and PC_Write=1 in that same cycle, next state DECODE.
  - DECODE (1): no enables. R/I/LUI -> EXEC; LW/SW -> ADDR; ILLEGAL -> FETCH (treated as NOP, not counted).
  - EXEC (2): ALU_Op = class code (R=000, I=001, LUI=010). ALU_Src_B=0 for R, 1 otherwise. Next state ALU_WB.
  - ALU_WB (3): ALU_Op and ALU_Src_B held from EXEC, Reg_Write=1, Mem_to_Reg=0. Next state FETCH; counter +1.
  - ADDR (4): ALU_Op=100 for LW, 011 for SW; ALU_Src_B=1. LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD (5): Mem_Read=1, I_or_D=1, ALU_Op/ALU_Src_B held. Wait for mem_ready_i, then MEM_WB.
  - MEM_WB (6): Reg_Write=1, Mem_to_Reg=1. Next state FETCH; counter +1.
  - MEM_WR (7): Mem_Write=1, I_or_D=1, ALU_Op/ALU_Src_B held. Wait for mem_ready_i, then FETCH; counter +1.
- Latency with zero-wait memory:
  - R/I/LUI = 4 cycles
  - LW = 5 cycles
  - SW = 4 cycles
  - each cycle mem_ready_i is low adds one cycle.
- Mem_Read_o and Mem_Write_o are never high together. Reg_Write_o is never high in the same cycle as either memory request.
- instr_count_o wraps from all-ones to 0 silently.
- mem_ready_i is ignored in DECODE, EXEC, ALU_WB, ADDR and MEM_WB.
- Reset asserted mid-instruction aborts it immediately: no writeback, counter cleared.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL class goes to a HALT state (encoding 3'd0 is not reused; state_o widens to 4 bits and HALT = 4'd8).
  - HALT asserts no enables and is left only by reset.
  - Extra output illegal_o (1 bit) is 1 while in HALT, 0 from reset.
- Undefined: ILLEGAL -> FETCH as above; no illegal_o port; state_o is 3 bits.

Test Plan:
- Reset: hold reset=0 with mem_ready_i=1 -> state_o=0, Mem_Read_o=1, all other enables 0, instr_count_o=0. Release reset -> next edge goes to DECODE with IR_Write_o/PC_Write_o pulsed for 1 cycle.
- ADD: opcode 0110011, mem_ready_i=1 -> states 0,1,2,3,0; ALU_Op_o=000 with ALU_Src_B_o=0 in EXEC; Reg_Write_o=1 one cycle; instr_count_o=1.
- LW with 2 wait states: opcode 0000011, mem_ready_i low for 2 cycles in MEM_RD -> states 0,1,4,5,5,5,6,0; ALU_Op_o=100; Mem_to_Reg_o=1 and Reg_Write_o=1 in MEM_WB.
- SW then ADDI back-to-back: opcodes 0100011 then 0010011 -> Mem_Write_o one cycle with ALU_Op_o=011, then EXEC with ALU_Op_o=001 and ALU_Src_B_o=1; instr_count_o=2.
- Illegal 1111111 -> states 0,1,0, counter unchanged. With ILLEGAL_TRAP_EN: HALT, illegal_o=1 held until reset.
- Async reset asserted during MEM_WR -> state_o=0 immediately, without waiting for a clock edge; Mem_Write_o drops; instr_count_o=0.
